// File: rtl/jogo_matriz_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jogo_matriz_pkg
// Brief   : Shared types, constants and the cross-toggle helper for the
//           lights-out matrix game.
// Revision: 1.0 - initial release
// ============================================================================
package jogo_matriz_pkg;

    localparam int c_nivel_w          = 3;
    localparam int c_def_n            = 8;
    localparam int c_def_num_niveis   = 4;
    localparam int c_def_max_jogadas  = 20;
    localparam int c_def_scan_div     = 1000;

    typedef enum logic [4:0] {
        INICIAL    = 5'd0,
        CARREGA    = 5'd1,
        JOGA       = 5'd2,
        AVALIA     = 5'd3,
        PROX_NIVEL = 5'd4,
        FIM_GANHOU = 5'd5,
        FIM_PERDEU = 5'd6
    } estado_t;

    // Row `linha` of the plus-shaped mask centred on (r,c); bits past the edge fall off.
    function automatic logic [7:0] cruz(input int linha, input int r, input int c);
        logic [7:0] col;
        col = 8'd1 << c;
        if (linha == r)
            cruz = col | (col << 1) | (col >> 1);
        else if ((linha == r - 1) || (linha == r + 1))
            cruz = col;
        else
            cruz = 8'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jogo_matriz_param_rom.sv
`default_nettype none
// ============================================================================
// Module  : niveis_rom
// Brief   : Combinational level ROM, one N-bit board row per {nivel, linha}.
// Revision: 1.0 - initial release
// ============================================================================
module niveis_rom
    import jogo_matriz_pkg::*;
#(
    parameter int N = c_def_n
) (
    input  logic [c_nivel_w-1:0] i_nivel,
    input  logic [2:0]           i_linha,
    output logic [N-1:0]         o_dados
);

    logic [7:0] w_padrao;

    // Every level is the footprint of one or two presses, so each is solvable.
    always_comb begin
        case (i_nivel)
            3'd0, 3'd4: w_padrao = cruz(int'(i_linha), 0, 0);
            3'd1, 3'd5: w_padrao = cruz(int'(i_linha), 1, 1);
            3'd2, 3'd6: w_padrao = cruz(int'(i_linha), N - 1, N - 1);
            default:    w_padrao = cruz(int'(i_linha), 0, N - 1) ^ cruz(int'(i_linha), N - 1, 0);
        endcase
        o_dados = w_padrao[N-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/jogo_matriz_param.sv
`default_nettype none
// ============================================================================
// Module  : jogo_matriz_param
// Brief   : Lights-out style matrix game with level ROM and row-scanned display.
// Revision: 1.0 - initial release
// ============================================================================
module jogo_matriz_param
    import jogo_matriz_pkg::*;
#(
    parameter int N           = c_def_n,
    parameter int NUM_NIVEIS  = c_def_num_niveis,
    parameter int MAX_JOGADAS = c_def_max_jogadas,
    parameter int SCAN_DIV    = c_def_scan_div
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         jogar,
    input  logic [N-1:0] botoes,
    input  logic         mover,
    output logic [N-1:0] colunas,
    output logic [N-1:0] linhas,
    output logic         ganhou,
    output logic         perdeu,
    output logic [4:0]   db_estado,
    output logic [2:0]   db_nivel,
    output logic [2:0]   db_cursor,
    output logic [7:0]   db_jogadas
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    estado_t                r_estado_q, w_estado_d;
    logic [N-1:0][N-1:0]    r_board_q, w_board_d;
    logic [c_nivel_w-1:0]   r_nivel_q, w_nivel_d;
    logic [2:0]             r_cursor_q, w_cursor_d;
    logic [2:0]             r_load_row_q, w_load_row_d;
    logic [2:0]             r_scan_row_q, w_scan_row_d;
    logic [7:0]             r_jogadas_q, w_jogadas_d;
    logic [c_div_w-1:0]     r_scan_div_q, w_scan_div_d;
    logic [15:0]            r_blink_q, w_blink_d;
    logic [N-1:0]           r_botoes_prev_q;
    logic                   r_mover_prev_q;
    logic [N-1:0]           r_colunas_q, w_colunas_d;
    logic [N-1:0]           r_linhas_q, w_linhas_d;
    logic                   r_ganhou_q, r_perdeu_q;

    logic [N-1:0]           w_edge_bot, w_rom_row;
    logic                   w_edge_mov, w_press_ok, w_scan_tick;
    logic [7:0]             w_mask;
    int                     w_col;

    niveis_rom #(.N(N)) u_rom (
        .i_nivel (r_nivel_q),
        .i_linha (r_load_row_q),
        .o_dados (w_rom_row)
    );

    always_comb begin
        w_edge_bot = botoes & ~r_botoes_prev_q;
        w_edge_mov = mover & ~r_mover_prev_q;
        w_press_ok = $onehot(w_edge_bot);
        w_col      = 0;
        for (int j = 0; j < N; j++)
            if (w_edge_bot[j]) w_col = j;
    end

    always_comb begin
        w_estado_d   = r_estado_q;
        w_board_d    = r_board_q;
        w_nivel_d    = r_nivel_q;
        w_cursor_d   = r_cursor_q;
        w_load_row_d = r_load_row_q;
        w_jogadas_d  = r_jogadas_q;
        w_mask       = 8'd0;
        case (r_estado_q)
            INICIAL: begin
                w_board_d = '0;
                if (jogar) begin
                    w_estado_d   = CARREGA;
                    w_nivel_d    = '0;
                    w_cursor_d   = 3'd0;
                    w_jogadas_d  = 8'd0;
                    w_load_row_d = 3'd0;
                end
            end
            CARREGA: begin
                for (int i = 0; i < N; i++)
                    if (i == int'(r_load_row_q)) w_board_d[i] = w_rom_row;
                if (int'(r_load_row_q) == N - 1) begin
                    w_load_row_d = 3'd0;
                    w_estado_d   = JOGA;
                end else begin
                    w_load_row_d = r_load_row_q + 3'd1;
                end
            end
            JOGA: begin
                // A column press wins; a simultaneous cursor move is simply lost.
                if (w_press_ok) begin
                    for (int i = 0; i < N; i++) begin
                        w_mask       = cruz(i, int'(r_cursor_q), w_col);
                        w_board_d[i] = r_board_q[i] ^ w_mask[N-1:0];
                    end
                    w_jogadas_d = (r_jogadas_q == 8'hFF) ? r_jogadas_q : r_jogadas_q + 8'd1;
                    w_estado_d  = AVALIA;
                end else if (w_edge_mov) begin
                    w_cursor_d = (int'(r_cursor_q) == N - 1) ? 3'd0 : r_cursor_q + 3'd1;
                end
            end
            AVALIA: begin
                if (r_board_q == '0)
                    w_estado_d = PROX_NIVEL;
                else if ((MAX_JOGADAS != 0) && (int'(r_jogadas_q) == MAX_JOGADAS))
                    w_estado_d = FIM_PERDEU;
                else
                    w_estado_d = JOGA;
            end
            PROX_NIVEL: begin
                if (int'(r_nivel_q) == NUM_NIVEIS - 1) begin
                    w_estado_d = FIM_GANHOU;
                end else begin
                    w_nivel_d    = r_nivel_q + 3'd1;
                    w_jogadas_d  = 8'd0;
                    w_cursor_d   = 3'd0;
                    w_load_row_d = 3'd0;
                    w_estado_d   = CARREGA;
                end
            end
            FIM_GANHOU, FIM_PERDEU: begin
                if (jogar) begin
                    w_estado_d   = CARREGA;
                    w_nivel_d    = '0;
                    w_cursor_d   = 3'd0;
                    w_jogadas_d  = 8'd0;
                    w_load_row_d = 3'd0;
                end
            end
            default: w_estado_d = INICIAL;
        endcase
    end

    always_comb begin
        w_scan_tick  = (r_scan_div_q == c_div_w'(SCAN_DIV - 1));
        w_scan_div_d = w_scan_tick ? '0 : r_scan_div_q + 1'b1;
        w_scan_row_d = r_scan_row_q;
        w_blink_d    = r_blink_q;
        if (w_scan_tick) begin
            w_scan_row_d = (int'(r_scan_row_q) == N - 1) ? 3'd0 : r_scan_row_q + 3'd1;
            w_blink_d    = r_blink_q + 16'd1;
        end
    end

    // Display registers are fed from next-state values so they line up with the scan row.
    always_comb begin
        w_linhas_d  = '0;
        w_colunas_d = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(w_scan_row_d)) begin
                w_linhas_d[i] = 1'b1;
                w_colunas_d   = w_board_d[i];
            end
        end
        if ((w_estado_d == JOGA) && (w_scan_row_d == w_cursor_d)) begin
            for (int j = 0; j < N; j++)
                if (j == int'(w_cursor_d)) w_colunas_d[j] = w_colunas_d[j] ^ w_blink_d[15];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado_q      <= INICIAL;
            r_board_q       <= '0;
            r_nivel_q       <= '0;
            r_cursor_q      <= 3'd0;
            r_load_row_q    <= 3'd0;
            r_scan_row_q    <= 3'd0;
            r_jogadas_q     <= 8'd0;
            r_scan_div_q    <= '0;
            r_blink_q       <= 16'd0;
            r_botoes_prev_q <= '0;
            r_mover_prev_q  <= 1'b0;
            r_colunas_q     <= '0;
            r_linhas_q      <= {{(N-1){1'b0}}, 1'b1};
            r_ganhou_q      <= 1'b0;
            r_perdeu_q      <= 1'b0;
        end else begin
            r_estado_q      <= w_estado_d;
            r_board_q       <= w_board_d;
            r_nivel_q       <= w_nivel_d;
            r_cursor_q      <= w_cursor_d;
            r_load_row_q    <= w_load_row_d;
            r_scan_row_q    <= w_scan_row_d;
            r_jogadas_q     <= w_jogadas_d;
            r_scan_div_q    <= w_scan_div_d;
            r_blink_q       <= w_blink_d;
            r_botoes_prev_q <= botoes;
            r_mover_prev_q  <= mover;
            r_colunas_q     <= w_colunas_d;
            r_linhas_q      <= w_linhas_d;
            r_ganhou_q      <= (w_estado_d == FIM_GANHOU);
            r_perdeu_q      <= (w_estado_d == FIM_PERDEU);
        end
    end

    assign colunas    = r_colunas_q;
    assign linhas     = r_linhas_q;
    assign ganhou     = r_ganhou_q;
    assign perdeu     = r_perdeu_q;
    assign db_estado  = r_estado_q;
    assign db_nivel   = r_nivel_q;
    assign db_cursor  = r_cursor_q;
    assign db_jogadas = r_jogadas_q;

endmodule
`default_nettype wire

// File: tb/tb_jogo_matriz_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_jogo_matriz_param
// Brief   : Directed, table-driven bench for jogo_matriz_param (N=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_jogo_matriz_param;
    import jogo_matriz_pkg::*;

    logic       clk, rst, jogar, mover;
    logic [3:0] botoes;

    logic [3:0] a_colunas, a_linhas, b_colunas, b_linhas;
    logic       a_ganhou, a_perdeu, b_ganhou, b_perdeu;
    logic [4:0] a_estado, b_estado;
    logic [2:0] a_nivel, a_cursor, b_nivel, b_cursor;
    logic [7:0] a_jogadas, b_jogadas;

    jogo_matriz_param #(.N(4), .NUM_NIVEIS(4), .MAX_JOGADAS(2), .SCAN_DIV(1)) dut_a (
        .clock(clk), .reset(rst), .jogar(jogar), .botoes(botoes), .mover(mover),
        .colunas(a_colunas), .linhas(a_linhas), .ganhou(a_ganhou), .perdeu(a_perdeu),
        .db_estado(a_estado), .db_nivel(a_nivel), .db_cursor(a_cursor), .db_jogadas(a_jogadas)
    );

    jogo_matriz_param #(.N(4), .NUM_NIVEIS(1), .MAX_JOGADAS(0), .SCAN_DIV(1)) dut_b (
        .clock(clk), .reset(rst), .jogar(jogar), .botoes(botoes), .mover(mover),
        .colunas(b_colunas), .linhas(b_linhas), .ganhou(b_ganhou), .perdeu(b_perdeu),
        .db_estado(b_estado), .db_nivel(b_nivel), .db_cursor(b_cursor), .db_jogadas(b_jogadas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bot;
        logic       mov;
        logic       jog;
        logic [4:0] est;
        logic [2:0] niv;
        logic [2:0] cur;
        logic [7:0] jgd;
        logic       per;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] b, input logic m, input logic j, input estado_t e,
                       input logic [2:0] n, input logic [2:0] c, input logic [7:0] g, input logic p);
        vec_t v;
        v.bot = b; v.mov = m; v.jog = j; v.est = e;
        v.niv = n; v.cur = c; v.jgd = g; v.per = p;
        vq.push_back(v);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            botoes = vq[i].bot;
            mover  = vq[i].mov;
            jogar  = vq[i].jog;
            step();
            chk($sformatf("v%0d_estado", i),  32'(a_estado),  32'(vq[i].est));
            chk($sformatf("v%0d_nivel", i),   32'(a_nivel),   32'(vq[i].niv));
            chk($sformatf("v%0d_cursor", i),  32'(a_cursor),  32'(vq[i].cur));
            chk($sformatf("v%0d_jogadas", i), 32'(a_jogadas), 32'(vq[i].jgd));
            chk($sformatf("v%0d_perdeu", i),  32'(a_perdeu),  32'(vq[i].per));
        end
        botoes = 4'b0000;
        mover  = 1'b0;
        jogar  = 1'b0;
    endtask

    // Scan four consecutive rows (SCAN_DIV=1) and rebuild the board from the display.
    task automatic read_board(input string nm, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] rows [4];
        logic [3:0] exp_r [4];
        exp_r[0] = e0; exp_r[1] = e1; exp_r[2] = e2; exp_r[3] = e3;
        for (int i = 0; i < 4; i++) rows[i] = 4'bxxxx;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("%s_onehot%0d", nm, k), 32'($onehot(a_linhas)), 32'd1);
            for (int i = 0; i < 4; i++)
                if (a_linhas[i]) rows[i] = a_colunas;
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_row%0d", nm, i), 32'(rows[i]), 32'(exp_r[i]));
    endtask

    initial begin
        rst = 1'b1; jogar = 1'b0; botoes = 4'b0000; mover = 1'b0;

        // Level 0 moves: cursor walk and wrap, multi-button edge ignored, then solve.
        add(4'b0000, 1, 0, JOGA, 0, 1, 0, 0);
        add(4'b0000, 1, 0, JOGA, 0, 1, 0, 0);
        add(4'b0000, 0, 0, JOGA, 0, 1, 0, 0);
        add(4'b0000, 1, 0, JOGA, 0, 2, 0, 0);
        add(4'b0000, 0, 0, JOGA, 0, 2, 0, 0);
        add(4'b0000, 1, 0, JOGA, 0, 3, 0, 0);
        add(4'b0000, 0, 0, JOGA, 0, 3, 0, 0);
        add(4'b0000, 1, 0, JOGA, 0, 0, 0, 0);
        add(4'b0101, 0, 0, JOGA, 0, 0, 0, 0);
        add(4'b0101, 0, 0, JOGA, 0, 0, 0, 0);
        add(4'b0000, 0, 0, JOGA, 0, 0, 0, 0);          // 10
        add(4'b0001, 0, 0, AVALIA, 0, 0, 1, 0);        // 11
        add(4'b0001, 0, 0, PROX_NIVEL, 0, 0, 1, 0);
        add(4'b0000, 0, 0, CARREGA, 1, 0, 0, 0);
        add(4'b0000, 0, 1, CARREGA, 1, 0, 0, 0);
        add(4'b0000, 0, 0, CARREGA, 1, 0, 0, 0);
        add(4'b0000, 0, 0, CARREGA, 1, 0, 0, 0);
        add(4'b0000, 0, 0, JOGA, 1, 0, 0, 0);          // 17
        // Level 1: column 3 held for 10 cycles counts once.
        add(4'b1000, 0, 0, AVALIA, 1, 0, 1, 0);        // 18
        for (int k = 0; k < 9; k++) add(4'b1000, 0, 0, JOGA, 1, 0, 1, 0);
        add(4'b0000, 0, 0, JOGA, 1, 0, 1, 0);          // 28
        // Press and mover together: press wins, second move hits the limit.
        add(4'b1000, 1, 0, AVALIA, 1, 0, 2, 0);        // 29
        add(4'b0000, 0, 0, FIM_PERDEU, 1, 0, 2, 1);
        add(4'b0000, 0, 0, FIM_PERDEU, 1, 0, 2, 1);    // 31
        add(4'b0000, 0, 1, CARREGA, 0, 0, 0, 0);       // 32
        add(4'b0000, 0, 0, CARREGA, 0, 0, 0, 0);

        step(); step();
        chk("rst_estado",  32'(a_estado),  32'(INICIAL));
        chk("rst_linhas",  32'(a_linhas),  32'h1);
        chk("rst_colunas", 32'(a_colunas), 32'h0);
        chk("rst_ganhou",  32'(a_ganhou),  32'h0);
        chk("rst_perdeu",  32'(a_perdeu),  32'h0);
        chk("rst_nivel",   32'(a_nivel),   32'h0);
        chk("rst_cursor",  32'(a_cursor),  32'h0);
        chk("rst_jogadas", 32'(a_jogadas), 32'h0);

        rst = 1'b0;
        step();
        chk("idle_estado", 32'(a_estado), 32'(INICIAL));
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        chk("start_estado", 32'(a_estado), 32'(CARREGA));
        step(); step(); step();
        chk("load3_estado", 32'(a_estado), 32'(CARREGA));
        step();
        chk("load4_estado", 32'(a_estado), 32'(JOGA));
        chk("load4_nivel",  32'(a_nivel),  32'h0);
        read_board("lvl0", 4'b0011, 4'b0001, 4'b0000, 4'b0000);

        run(0, 10);
        read_board("multi", 4'b0011, 4'b0001, 4'b0000, 4'b0000);
        run(11, 17);
        read_board("lvl1", 4'b0010, 4'b0111, 4'b0010, 4'b0000);
        run(18, 28);
        read_board("press3", 4'b1110, 4'b1111, 4'b0010, 4'b0000);
        run(29, 31);
        read_board("frozen", 4'b0010, 4'b0111, 4'b0010, 4'b0000);
        chk("frozen_estado", 32'(a_estado), 32'(FIM_PERDEU));
        run(32, 33);

        // Single-level instance: solve level 0, win, restart, reset mid-load.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        step(); step(); step(); step();
        chk("b_load_estado", 32'(b_estado), 32'(JOGA));
        botoes = 4'b0001;
        step();
        botoes = 4'b0000;
        chk("b_avalia", 32'(b_estado), 32'(AVALIA));
        step();
        chk("b_prox", 32'(b_estado), 32'(PROX_NIVEL));
        step();
        chk("b_fim_estado", 32'(b_estado), 32'(FIM_GANHOU));
        chk("b_ganhou",     32'(b_ganhou), 32'h1);
        chk("b_perdeu",     32'(b_perdeu), 32'h0);
        step();
        chk("b_ganhou_hold", 32'(b_ganhou), 32'h1);
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        chk("b_restart_estado", 32'(b_estado), 32'(CARREGA));
        chk("b_restart_ganhou", 32'(b_ganhou), 32'h0);
        step();
        chk("b_midload_estado", 32'(b_estado), 32'(CARREGA));
        rst = 1'b1;
        step();
        chk("b_rst_estado",  32'(b_estado),  32'(INICIAL));
        chk("b_rst_linhas",  32'(b_linhas),  32'h1);
        chk("b_rst_colunas", 32'(b_colunas), 32'h0);
        chk("b_rst_ganhou",  32'(b_ganhou),  32'h0);
        chk("b_rst_perdeu",  32'(b_perdeu),  32'h0);
        chk("b_rst_nivel",   32'(b_nivel),   32'h0);
        chk("b_rst_cursor",  32'(b_cursor),  32'h0);
        chk("b_rst_jogadas", 32'(b_jogadas), 32'h0);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
